// File: rtl/abro_n_sync_pkg.sv
// Shared definitions for the N-input ABRO controller: one-hot states and
// the width helper for the arrival-window counter.
package abro_pkg;

   localparam int unsigned ST_W = 4;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE    = 4'b0001,
      ST_COLLECT = 4'b0010,
      ST_EMIT    = 4'b0100,
      ST_DONE    = 4'b1000
   } state_t;

   // Counter only has to represent 0 .. limit-1, never narrower than one bit.
   function automatic int unsigned tmo_cnt_w(input int unsigned limit);
      return (limit < 2) ? 1 : $clog2(limit);
   endfunction

endpackage

// File: rtl/abro_n_sync_tmo_ctr.sv
// Arrival-window counter: held at zero while cleared, counts while enabled,
// and flags the cycle on which the TIMEOUT-th enabled count would land.
module abro_tmo_ctr
   import abro_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int unsigned CW = tmo_cnt_w(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/abro_n_sync.sv
// N-input ABRO controller: await every in_evt channel, emit O, restart on R.
// Optional arrival-window abort compiled in with ABRO_TIMEOUT_EN.
module abro_n_sync
   import abro_pkg::*;
#(
   parameter int unsigned N_IN       = 2,
   parameter int unsigned PULSE_MODE = 1,
   parameter int unsigned TIMEOUT    = 16,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IN-1:0]  in_evt,
   input  logic             R,
   output logic             O,
   output logic [ST_W-1:0]  State,
   output logic [N_IN-1:0]  seen,
   output logic [CNT_W-1:0] done_cnt,
   output logic             tmo_err
);

   localparam logic HOLD_O = (PULSE_MODE == 0);

   state_t           r_state;
   state_t           w_nxt_state;
   logic [N_IN-1:0]  r_seen;
   logic [N_IN-1:0]  w_nxt_seen;
   logic [N_IN-1:0]  w_acc;
   logic             w_all;
   logic             r_o;
   logic             w_nxt_o;
   logic [CNT_W-1:0] r_done_cnt;
   logic             w_cnt_inc;
   logic             w_expire;
   logic             w_nxt_tmo;

   assign w_acc = r_seen | in_evt;
   assign w_all = &w_acc;

`ifdef ABRO_TIMEOUT_EN
   logic r_tmo;

   abro_tmo_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk      (clk),
      .reset    (reset),
      .i_clr    (r_state != ST_COLLECT),
      .i_en     (r_state == ST_COLLECT),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tmo <= 1'b0;
      end else begin
         r_tmo <= w_nxt_tmo;
      end
   end

   assign tmo_err = r_tmo;
`else
   logic w_unused_timeout;

   assign w_expire         = 1'b0;
   assign w_unused_timeout = ^{TIMEOUT, w_nxt_tmo};
   assign tmo_err          = 1'b0;
`endif

   // R is checked first so that it beats both completion and timeout.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_seen  = r_seen;
      w_nxt_o     = 1'b0;
      w_nxt_tmo   = 1'b0;
      w_cnt_inc   = 1'b0;
      if (R) begin
         w_nxt_state = ST_IDLE;
         w_nxt_seen  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_nxt_seen = w_acc;
               if (w_all) begin
                  w_nxt_state = ST_EMIT;
                  w_nxt_o     = 1'b1;
                  w_cnt_inc   = 1'b1;
               end else if (|w_acc) begin
                  w_nxt_state = ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               w_nxt_seen = w_acc;
               if (w_all) begin
                  w_nxt_state = ST_EMIT;
                  w_nxt_o     = 1'b1;
                  w_cnt_inc   = 1'b1;
               end else if (w_expire) begin
                  w_nxt_state = ST_IDLE;
                  w_nxt_seen  = '0;
                  w_nxt_tmo   = 1'b1;
               end
            end
            ST_EMIT: begin
               w_nxt_state = ST_DONE;
               w_nxt_o     = HOLD_O;
            end
            ST_DONE: begin
               w_nxt_o = HOLD_O;
            end
            default: begin
               w_nxt_state = ST_IDLE;
               w_nxt_seen  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_seen     <= '0;
         r_o        <= 1'b0;
         r_done_cnt <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_seen  <= w_nxt_seen;
         r_o     <= w_nxt_o;
         if (w_cnt_inc) begin
            r_done_cnt <= r_done_cnt + 1'b1;
         end
      end
   end

   assign State    = r_state;
   assign seen     = r_seen;
   assign O        = r_o;
   assign done_cnt = r_done_cnt;

endmodule

// File: tb/tb_abro_n_sync.sv
// Bench for abro_n_sync: pulse-mode and level-mode instances share stimulus
// and are compared against a behavioural model after every clock edge.
module tb_abro_n_sync;

   localparam int unsigned NI  = 3;
   localparam int unsigned TMO = 8;
`ifdef ABRO_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic       clk    = 1'b0;
   logic       reset  = 1'b1;
   logic [2:0] in_evt = '0;
   logic       R      = 1'b0;

   logic       O_p, O_l, tmo_p, tmo_l;
   logic [3:0] st_p, st_l;
   logic [2:0] seen_p, seen_l;
   logic [7:0] cnt_p, cnt_l;
   logic [16:0] obs [2];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   abro_n_sync #(.N_IN(NI), .PULSE_MODE(1), .TIMEOUT(TMO), .CNT_W(8)) dut_pulse (
      .clk(clk), .reset(reset), .in_evt(in_evt), .R(R), .O(O_p), .State(st_p),
      .seen(seen_p), .done_cnt(cnt_p), .tmo_err(tmo_p));

   abro_n_sync #(.N_IN(NI), .PULSE_MODE(0), .TIMEOUT(TMO), .CNT_W(8)) dut_level (
      .clk(clk), .reset(reset), .in_evt(in_evt), .R(R), .O(O_l), .State(st_l),
      .seen(seen_l), .done_cnt(cnt_l), .tmo_err(tmo_l));

   assign obs[0] = {st_p, O_p, seen_p, cnt_p, tmo_p};
   assign obs[1] = {st_l, O_l, seen_l, cnt_l, tmo_l};

   // Model: phase 0=idle 1=collecting 2=emitting 3=done; index 1 is level mode.
   int         m_phase [2];
   logic [2:0] m_seen  [2];
   logic       m_o     [2];
   int         m_cnt   [2];
   logic       m_tmo   [2];
   int         m_age   [2];

   task automatic model_step(input int k);
      logic [2:0] acc;
      m_tmo[k] = 1'b0;
      if (reset) begin
         m_phase[k] = 0; m_seen[k] = '0; m_o[k] = 1'b0; m_cnt[k] = 0; m_age[k] = 0;
      end else if (R) begin
         m_phase[k] = 0; m_seen[k] = '0; m_o[k] = 1'b0; m_age[k] = 0;
      end else if (m_phase[k] <= 1) begin
         acc = m_seen[k] | in_evt;
         m_o[k] = 1'b0;
         if (acc == 3'b111) begin
            m_phase[k] = 2; m_seen[k] = acc; m_o[k] = 1'b1;
            m_cnt[k] = (m_cnt[k] + 1) % 256;
         end else if (m_phase[k] == 0) begin
            m_seen[k] = acc; m_age[k] = 0;
            m_phase[k] = (acc != 0) ? 1 : 0;
         end else begin
            m_age[k] = m_age[k] + 1;
            if (TMO_EN && m_age[k] == TMO) begin
               m_phase[k] = 0; m_seen[k] = '0; m_tmo[k] = 1'b1;
            end else begin
               m_seen[k] = acc;
            end
         end
      end else begin
         m_phase[k] = 3;
         m_o[k] = (k == 1);
      end
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) model_step(k);
   end

   function automatic logic [16:0] expect_of(input int k);
      return {4'(1 << m_phase[k]), m_o[k], m_seen[k], 8'(m_cnt[k]), m_tmo[k]};
   endfunction

   task automatic drive(input logic [2:0] e, input logic r, input logic rst);
      @(negedge clk);
      in_evt = e; R = r; reset = rst;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         drive(3'b111, 1'b0, 1'b1);
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs[k] !== 17'b0001_0_000_00000000_0) begin
               n_bad++;
               $display("FAIL reset dut%0d: got %b want %b", k, obs[k], 17'b0001_0_000_00000000_0);
            end
            n_cmp++;
            if (obs[k] !== expect_of(k)) begin
               n_bad++;
               $display("FAIL reset_model dut%0d: got %b want %b", k, obs[k], expect_of(k));
            end
         end
      end
      drive(3'b000, 1'b0, 1'b0);
   endtask

   task automatic test_all_at_once();
      drive(3'b111, 1'b0, 1'b0);
      n_cmp++;
      if ({st_p, O_p, cnt_p} !== {4'b0100, 1'b1, 8'd1}) begin
         n_bad++;
         $display("FAIL all_emit: got st=%b O=%b cnt=%0d want st=0100 O=1 cnt=1", st_p, O_p, cnt_p);
      end
      drive(3'b000, 1'b0, 1'b0);
      n_cmp++;
      if ({st_p, O_p, seen_p, O_l} !== {4'b1000, 1'b0, 3'b111, 1'b1}) begin
         n_bad++;
         $display("FAIL all_done: got st=%b O=%b seen=%b O_l=%b want 1000 0 111 1", st_p, O_p, seen_p, O_l);
      end
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (obs[k] !== expect_of(k)) begin
            n_bad++;
            $display("FAIL all_model dut%0d: got %b want %b", k, obs[k], expect_of(k));
         end
      end
   endtask

   task automatic test_sequence();
      logic [2:0] ev [5] = '{3'b001, 3'b000, 3'b100, 3'b010, 3'b000};
      logic [3:0] st [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
      logic [2:0] sn [5] = '{3'b001, 3'b001, 3'b101, 3'b111, 3'b111};
      drive(3'b000, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(ev[i], 1'b0, 1'b0);
         n_cmp++;
         if ({st_p, seen_p} !== {st[i], sn[i]}) begin
            n_bad++;
            $display("FAIL seq[%0d]: got st=%b seen=%b want st=%b seen=%b", i, st_p, seen_p, st[i], sn[i]);
         end
      end
      drive(3'b000, 1'b1, 1'b0);
      n_cmp++;
      if ({st_p, seen_p, cnt_p} !== {4'b0001, 3'b000, 8'd2}) begin
         n_bad++;
         $display("FAIL seq_restart: got st=%b seen=%b cnt=%0d want 0001 000 2", st_p, seen_p, cnt_p);
      end
   endtask

   task automatic test_timeout();
      int tmo_hits = 0;
      int o_hits = 0;
      drive(3'b010, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         drive(3'b000, 1'b0, 1'b0);
         tmo_hits += int'(tmo_p);
         o_hits += int'(O_p);
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs[k] !== expect_of(k)) begin
               n_bad++;
               $display("FAIL tmo_model[%0d] dut%0d: got %b want %b", i, k, obs[k], expect_of(k));
            end
         end
      end
      n_cmp++;
      if (tmo_hits !== int'(TMO_EN) || o_hits !== 0 || st_p !== (TMO_EN ? 4'b0001 : 4'b0010)) begin
         n_bad++;
         $display("FAIL tmo_abort: got hits=%0d O_hits=%0d st=%b want hits=%0d O_hits=0", tmo_hits, o_hits, st_p, int'(TMO_EN));
      end
      drive(3'b000, 1'b1, 1'b0);
      drive(3'b010, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) drive(3'b000, 1'b0, 1'b0);
      drive(3'b101, 1'b0, 1'b0);
      n_cmp++;
      if ({st_p, O_p, tmo_p} !== {4'b0100, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL tmo_complete_wins: got st=%b O=%b tmo=%b want 0100 1 0", st_p, O_p, tmo_p);
      end
      drive(3'b000, 1'b1, 1'b0);
   endtask

   task automatic test_r_beats_completion();
      logic [7:0] saved;
      drive(3'b001, 1'b0, 1'b0);
      drive(3'b010, 1'b0, 1'b0);
      saved = 8'(m_cnt[0]);
      drive(3'b100, 1'b1, 1'b0);
      n_cmp++;
      if ({st_p, seen_p, cnt_p, O_p} !== {4'b0001, 3'b000, saved, 1'b0}) begin
         n_bad++;
         $display("FAIL r_beats: got st=%b seen=%b cnt=%0d want 0001 000 %0d", st_p, seen_p, cnt_p, saved);
      end
      drive(3'b011, 1'b0, 1'b0);
      drive(3'b000, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (obs[k] !== 17'b0001_0_000_00000000_0) begin
            n_bad++;
            $display("FAIL mid_reset dut%0d: got %b want %b", k, obs[k], 17'b0001_0_000_00000000_0);
         end
      end
      drive(3'b000, 1'b0, 1'b0);
   endtask

   task automatic test_level_hold();
      drive(3'b111, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(3'b000, 1'b0, 1'b0);
         n_cmp++;
         if ({st_l, O_l, O_p} !== {4'b1000, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL level_hold[%0d]: got st=%b O_l=%b O_p=%b want 1000 1 0", i, st_l, O_l, O_p);
         end
      end
      drive(3'b111, 1'b1, 1'b0);
      n_cmp++;
      if ({st_l, O_l, seen_l} !== {4'b0001, 1'b0, 3'b000}) begin
         n_bad++;
         $display("FAIL level_drop: got st=%b O=%b seen=%b want 0001 0 000", st_l, O_l, seen_l);
      end
      drive(3'b111, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (obs[k] !== expect_of(k)) begin
            n_bad++;
            $display("FAIL recapture dut%0d: got %b want %b", k, obs[k], expect_of(k));
         end
      end
      drive(3'b000, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [2:0] e;
      for (int i = 0; i < 400; i++) begin
         e = 3'($urandom) & 3'($urandom) & 3'($urandom);
         drive(e, ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0));
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs[k] !== expect_of(k)) begin
               n_bad++;
               $display("FAIL random[%0d] dut%0d: got %b want %b", i, k, obs[k], expect_of(k));
            end
         end
      end
      drive(3'b000, 1'b1, 1'b0);
   endtask

   task automatic test_wrap();
      drive(3'b000, 1'b0, 1'b1);
      drive(3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 256; i++) begin
         drive(3'b111, 1'b0, 1'b0);
         if (i == 254) begin
            n_cmp++;
            if ({cnt_p, cnt_l} !== {8'd255, 8'd255}) begin
               n_bad++;
               $display("FAIL wrap_255: got %0d/%0d want 255/255", cnt_p, cnt_l);
            end
         end
         drive(3'b111, 1'b1, 1'b0);
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs[k] !== expect_of(k)) begin
               n_bad++;
               $display("FAIL wrap_model[%0d] dut%0d: got %b want %b", i, k, obs[k], expect_of(k));
            end
         end
      end
      n_cmp++;
      if ({cnt_p, cnt_l} !== 16'd0) begin
         n_bad++;
         $display("FAIL wrap_zero: got %0d/%0d want 0/0", cnt_p, cnt_l);
      end
   endtask

   initial begin
      test_reset();
      test_all_at_once();
      test_sequence();
      test_timeout();
      test_r_beats_completion();
      test_level_hold();
      test_random();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
